// File: rtl/entity_priority_resolver.sv
// rtl/entity_priority_resolver.sv - per-pixel entity slot hit detection with lowest-slot priority
// Optional collision flag: define ENTITY_COLLISION_DETECT_EN.
module entity_priority_resolver #(
    parameter int          NUM_SLOTS = 9,
    parameter logic [15:0] FLIP_MASK = 16'h0180,
    parameter int          UPSCALE   = 5,
    parameter int          TILE_SIZE = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [3:0]  i_wr_slot,
    input  logic [13:0] i_wr_data,
    input  logic        i_frame_start,
    input  logic [9:0]  i_counter_H,
    input  logic [9:0]  i_counter_V,
    output logic [8:0]  o_out_entity,
    output logic [3:0]  o_out_slot,
    output logic        o_collision
);

    localparam int          TILE_LEN = TILE_SIZE * UPSCALE;
    localparam logic [13:0] UNUSED   = 14'h3C00;

    logic [13:0] r_shadow [NUM_SLOTS];
    logic [13:0] r_active [NUM_SLOTS];

    logic                 w_wr_accept;
    logic [10:0]          w_h;
    logic [10:0]          w_v;
    logic [NUM_SLOTS-1:0] w_hit;
    logic [2:0]           w_line [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] r_hit;
    logic [2:0]           r_line [NUM_SLOTS];
    logic [5:0]           r_attr [NUM_SLOTS];

    logic [8:0]           w_sel_entity;
    logic [3:0]           w_sel_slot;
    logic [8:0]           r_out_entity;
    logic [3:0]           r_out_slot;

    assign o_wr_ready  = ~(i_frame_start | i_reset);
    assign w_wr_accept = i_wr_valid & o_wr_ready;
    assign w_h         = {1'b0, i_counter_H};
    assign w_v         = {1'b0, i_counter_V};

    // Slots beyond NUM_SLOTS match no entry, so such writes are silently dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int n = 0; n < NUM_SLOTS; n++) begin
                r_shadow[n] <= UNUSED;
                r_active[n] <= UNUSED;
            end
        end else begin
            for (int n = 0; n < NUM_SLOTS; n++) begin
                if (w_wr_accept && i_wr_slot == 4'(n))
                    r_shadow[n] <= i_wr_data;
                if (i_frame_start)
                    r_active[n] <= r_shadow[n];
            end
        end
    end

    for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_slot
        logic [10:0] w_x0;
        logic [10:0] w_y0;
        logic [10:0] w_dv;
        logic [10:0] w_row;

        assign w_x0  = 11'(r_active[n][3:0]) * 11'(TILE_LEN);
        assign w_y0  = 11'(r_active[n][7:4]) * 11'(TILE_LEN);
        assign w_dv  = w_v - w_y0;
        assign w_row = w_dv / 11'(UPSCALE);

        assign w_hit[n] = (r_active[n][13:10] != 4'hF) &&
                          (w_h >= w_x0) && (w_h < w_x0 + 11'(TILE_LEN)) &&
                          (w_v >= w_y0) && (w_v < w_y0 + 11'(TILE_LEN));
        assign w_line[n] = FLIP_MASK[n] ? (3'd7 - w_row[2:0]) : w_row[2:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hit <= '0;
            for (int n = 0; n < NUM_SLOTS; n++) begin
                r_line[n] <= 3'd0;
                r_attr[n] <= 6'd0;
            end
        end else begin
            r_hit <= w_hit;
            for (int n = 0; n < NUM_SLOTS; n++) begin
                r_line[n] <= w_line[n];
                r_attr[n] <= r_active[n][13:8];
            end
        end
    end

    // Scan from the top so the lowest hitting slot is the last one to assign.
    always_comb begin
        w_sel_entity = 9'h1FF;
        w_sel_slot   = 4'hF;
        for (int n = NUM_SLOTS - 1; n >= 0; n--) begin
            if (r_hit[n]) begin
                w_sel_entity = {r_line[n], r_attr[n]};
                w_sel_slot   = 4'(n);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_entity <= 9'h1FF;
            r_out_slot   <= 4'hF;
        end else begin
            r_out_entity <= w_sel_entity;
            r_out_slot   <= w_sel_slot;
        end
    end

    assign o_out_entity = r_out_entity;
    assign o_out_slot   = r_out_slot;

`ifdef ENTITY_COLLISION_DETECT_EN
    logic w_multi_hit;
    logic r_collision;

    // Clearing one set bit leaves a nonzero vector only if two or more were set.
    assign w_multi_hit = |(r_hit & (r_hit - {{(NUM_SLOTS-1){1'b0}}, 1'b1}));

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_collision <= 1'b0;
        else if (w_multi_hit)
            r_collision <= 1'b1;
        else if (i_frame_start)
            r_collision <= 1'b0;
    end

    assign o_collision = r_collision;
`else
    assign o_collision = 1'b0;
`endif

endmodule
